// File: rtl/scoreboard_pkg.sv
// Shared definitions for the basketball score controller: FSM encoding,
// parameter defaults and BCD score layout.
package scoreboard_pkg;

    localparam int DIGIT_W         = 4;
    localparam int SCORE_W         = 3 * DIGIT_W;
    localparam int MAX_SCORE_DEF   = 199;
    localparam int FLASH_TICKS_DEF = 50;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ADD  = 1'b1
    } state_t;

    // Binary to {hundreds, tens, ones}; used only on elaboration-time constants.
    function automatic logic [SCORE_W-1:0] to_bcd(input int v);
        return {DIGIT_W'((v / 100) % 10), DIGIT_W'((v / 10) % 10), DIGIT_W'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_score_cnt.sv
// Three-digit BCD score register: +1 per enabled cycle, holds at MAX_SCORE,
// synchronous clear.
module bcd_score_cnt
    import scoreboard_pkg::*;
#(
    parameter int MAX_SCORE = MAX_SCORE_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_inc,
    output logic [SCORE_W-1:0] o_score
);

    localparam logic [SCORE_W-1:0] MAX_BCD = to_bcd(MAX_SCORE);

    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_next;
    logic [DIGIT_W-1:0] w_hun, w_ten, w_one;

    assign {w_hun, w_ten, w_one} = r_score;

    always_comb begin
        w_next = r_score;
        if (w_one != DIGIT_W'(9)) begin
            w_next = {w_hun, w_ten, w_one + 1'b1};
        end else if (w_ten != DIGIT_W'(9)) begin
            w_next = {w_hun, w_ten + 1'b1, DIGIT_W'(0)};
        end else begin
            w_next = {w_hun + 1'b1, DIGIT_W'(0), DIGIT_W'(0)};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_score <= '0;
        end else if (i_inc && (r_score != MAX_BCD)) begin
            r_score <= w_next;
        end
    end

    assign o_score = r_score;

endmodule

// File: rtl/score_ctrl.sv
// Score controller: accepts +1/+2/+3 requests for the team in possession,
// applies them one point per cycle with a one-deep pending slot.
//   state  | meaning
//   S_IDLE | no add in progress
//   S_ADD  | adding one point per cycle to r_team, r_cnt points remaining
module score_ctrl
    import scoreboard_pkg::*;
#(
    parameter int MAX_SCORE   = MAX_SCORE_DEF,
    parameter int FLASH_TICKS = FLASH_TICKS_DEF
) (
    input  logic               i_clk_db,
    input  logic               i_rst,
    input  logic               i_clr_p,
    input  logic               i_add1_p,
    input  logic               i_add2_p,
    input  logic               i_add3_p,
    input  logic               i_poss_a,
    input  logic               i_poss_b,
    output logic [SCORE_W-1:0] o_score_a,
    output logic [SCORE_W-1:0] o_score_b,
    output logic [1:0]         o_poss_led,
    output logic               o_poss_err,
    output logic               o_busy,
    output logic               o_flash_a,
    output logic               o_flash_b,
    output logic               o_drop_p
);

    localparam int            FW         = (FLASH_TICKS > 0) ? $clog2(FLASH_TICKS + 1) : 1;
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_TICKS);

    state_t        r_state, w_state;
    logic [1:0]    r_cnt, w_cnt, r_pend_pts, w_pend_pts;
    logic          r_team, w_team, r_pend_v, w_pend_v, r_pend_team, w_pend_team;
    logic [FW-1:0] r_flash_a, w_flash_a, r_flash_b, w_flash_b;
    logic          r_drop, w_drop;
    logic [1:0]    r_poss_led;
    logic          r_poss_err;

    logic       w_any, w_multi, w_req, w_req_team, w_final, w_inc_a, w_inc_b;
    logic [1:0] w_pts;

    assign w_any      = i_add1_p | i_add2_p | i_add3_p;
    assign w_multi    = (i_add1_p & i_add2_p) | (i_add1_p & i_add3_p) | (i_add2_p & i_add3_p);
    assign w_pts      = i_add3_p ? 2'd3 : (i_add2_p ? 2'd2 : 2'd1);
    assign w_req      = w_any & (i_poss_a ^ i_poss_b);
    assign w_req_team = i_poss_b;
    assign w_final    = (r_state == S_ADD) && (r_cnt == 2'd1);
    assign w_inc_a    = (r_state == S_ADD) && !r_team;
    assign w_inc_b    = (r_state == S_ADD) && r_team;

    bcd_score_cnt #(.MAX_SCORE(MAX_SCORE)) u_score_a (
        .i_clk(i_clk_db), .i_rst(i_rst), .i_clr(i_clr_p), .i_inc(w_inc_a), .o_score(o_score_a)
    );
    bcd_score_cnt #(.MAX_SCORE(MAX_SCORE)) u_score_b (
        .i_clk(i_clk_db), .i_rst(i_rst), .i_clr(i_clr_p), .i_inc(w_inc_b), .o_score(o_score_b)
    );

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_team      = r_team;
        w_pend_v    = r_pend_v;
        w_pend_pts  = r_pend_pts;
        w_pend_team = r_pend_team;
        w_flash_a   = r_flash_a;
        w_flash_b   = r_flash_b;
        w_drop      = 1'b0;
        if (r_flash_a != '0) w_flash_a = r_flash_a - 1'b1;
        if (r_flash_b != '0) w_flash_b = r_flash_b - 1'b1;

        if (i_clr_p) begin
            w_state   = S_IDLE;
            w_cnt     = 2'd0;
            w_pend_v  = 1'b0;
            w_flash_a = '0;
            w_flash_b = '0;
            w_drop    = w_any;
        end else begin
            w_drop = w_multi | (w_any & ~(i_poss_a ^ i_poss_b));
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        w_state = S_ADD;
                        w_cnt   = w_pts;
                        w_team  = w_req_team;
                    end
                end
                S_ADD: begin
                    w_cnt = r_cnt - 2'd1;
                    if (w_final) begin
                        if (r_team) w_flash_b = FLASH_LOAD;
                        else        w_flash_a = FLASH_LOAD;
                        // The pending slot frees up on this edge, so a new request may refill it.
                        if (r_pend_v) begin
                            w_cnt       = r_pend_pts;
                            w_team      = r_pend_team;
                            w_pend_v    = w_req;
                            w_pend_pts  = w_pts;
                            w_pend_team = w_req_team;
                        end else if (w_req) begin
                            w_cnt  = w_pts;
                            w_team = w_req_team;
                        end else begin
                            w_state = S_IDLE;
                        end
                    end else if (w_req) begin
                        if (!r_pend_v) begin
                            w_pend_v    = 1'b1;
                            w_pend_pts  = w_pts;
                            w_pend_team = w_req_team;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_db) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_team      <= 1'b0;
            r_pend_v    <= 1'b0;
            r_pend_pts  <= 2'd0;
            r_pend_team <= 1'b0;
            r_flash_a   <= '0;
            r_flash_b   <= '0;
            r_drop      <= 1'b0;
            r_poss_led  <= 2'b00;
            r_poss_err  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_team      <= w_team;
            r_pend_v    <= w_pend_v;
            r_pend_pts  <= w_pend_pts;
            r_pend_team <= w_pend_team;
            r_flash_a   <= w_flash_a;
            r_flash_b   <= w_flash_b;
            r_drop      <= w_drop;
            r_poss_led  <= {i_poss_b & ~i_poss_a, i_poss_a & ~i_poss_b};
            r_poss_err  <= (i_poss_a == i_poss_b);
        end
    end

    assign o_busy     = (r_state == S_ADD);
    assign o_flash_a  = (r_flash_a != '0);
    assign o_flash_b  = (r_flash_b != '0);
    assign o_drop_p   = r_drop;
    assign o_poss_led = r_poss_led;
    assign o_poss_err = r_poss_err;

endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 Parameter MAX_SCORE, default 199, saturation ceiling for each team score.
REQ-002 Parameter FLASH_TICKS, default 50, scoring-flash duration in clk_db cycles (0.5 s at 100 Hz).
REQ-003 clk_db  in  1  debounce-domain clock (100 Hz), sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 clr_p  in  1  one-cycle pulse, clear both scores (debounced S0).
REQ-006 add1_p / add2_p / add3_p  in  1 each  one-cycle pulses, +1/+2/+3 points (debounced S1..S3).
REQ-007 poss_a / poss_b  in  1 each  debounced possession levels (SW0 Team A, SW7 Team B).
REQ-008 score_a / score_b  out  12 each  BCD score {hundreds, tens, ones}.
REQ-009 poss_led  out  2  {B,A} valid-possession indicator.
REQ-010 poss_err  out  1  high when poss_a == poss_b.
REQ-011 busy  out  1  high while state is ADD.
REQ-012 flash_a / flash_b  out  1 each  high for FLASH_TICKS cycles after that team's add completes.
REQ-013 drop_p  out  1  one-cycle pulse when a point request is discarded.

Function
REQ-014 FSM states IDLE and ADD; IDLE -> ADD on accepted request; ADD -> IDLE when step count exhausted and pending empty; ADD -> ADD (reload) when exhausted and pending full.
REQ-015 Request valid only if exactly one possession level high; team latched from possession at the acceptance edge; later switch changes do not redirect it.
REQ-016 Point pulse with poss_err high: ignored, drop_p asserted next cycle.
REQ-017 Same-cycle point pulses: priority add3 > add2 > add1; winner accepted, each loser causes one drop_p (single pulse per cycle regardless of loser count).
REQ-018 Request at edge t from IDLE: busy high t+1..t+n, score incremented by exactly 1 on each of edges t+1..t+n (n = 1/2/3), busy low at t+n+1 if no pending.
REQ-019 BCD increment: ones 9 -> 0 carries to tens; tens 9 -> 0 carries to hundreds; all digits always 0..9.
REQ-020 Score at MAX_SCORE: further increments have no effect; ADD still consumes its n cycles.
REQ-021 Request arriving while busy: stored in a 1-deep pending register (points, team) if empty; else discarded with drop_p.
REQ-022 Pending request starts on the cycle after the current add's final increment, with no IDLE cycle between.
REQ-023 clr_p overrides all: next edge scores = 0, state IDLE, pending emptied, flashes cleared; point pulses in the same cycle dropped (drop_p).
REQ-024 On completion of an add (final increment edge) the team's flash counter loads FLASH_TICKS; flash high while counter nonzero; reload on a new completion.
REQ-025 poss_led and poss_err registered, one-cycle latency from poss_a/poss_b.

Reset
REQ-026 rst high at a rising edge: scores 000, state IDLE, pending empty, busy 0, flash_a/b 0, drop_p 0, poss_led 00, poss_err 0.
REQ-027 rst mid-ADD aborts the add with no partial completion and no flash.

Structure
REQ-028 Shared package scoreboard_pkg holds FSM state encoding, MAX_SCORE and FLASH_TICKS defaults, and BCD digit width.
REQ-029 One sub-module bcd_score_cnt (3-digit BCD saturating incrementer with synchronous clear), instantiated per team.

Verification
REQ-030 poss_a=1, add3_p at t -> score_a 000,001,002,003 at t+1..t+3; busy t+1..t+3; flash_a high FLASH_TICKS cycles from t+3.
REQ-031 score_b=098 (poss_b), add2_p -> 099 then 100; BCD carries correct.
REQ-032 score_a=198, add3_p -> 199, 199, busy 3 cycles, no overflow.
REQ-033 add1_p+add3_p same cycle -> +3 applied, one drop_p; during that add, add2_p queued, third request dropped; total +5, no idle gap.
REQ-034 poss_a=poss_b=1, add2_p -> scores unchanged, poss_err=1, drop_p pulse.
REQ-035 clr_p mid-ADD with pending full -> both scores 000 next edge, busy 0, pending discarded, flashes 0.
